// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//
// Bridges a single-issue core data port to a request/acknowledge memory port.
// Each core access is latched once and presented to memory as a stable
// registered request until the memory acknowledges it or a timeout expires.
// The core is frozen through the stall output until the access is finished.
//
// Parameters
//   TIMEOUT_CYC  maximum number of BUSY cycles spent waiting for mem_ack
//                (1..65535)
//
// Ports
//   clka        in   1   clock, rising edge
//   rst         in   1   asynchronous active-low reset
//   cpu_en      in   1   core access request, held while stall=1
//   cpu_we      in   1   1 = store, 0 = load
//   cpu_addr    in   32  byte address of the access
//   cpu_wdata   in   32  store data
//   cpu_rdata   out  32  load data (registered), valid in DONE
//   stall       out  1   freezes the core pipeline while high (combinational)
//   err         out  1   one-cycle pulse on misaligned address or timeout
//   mem_req     out  1   memory request (registered)
//   mem_we      out  1   latched write enable
//   mem_addr    out  32  latched address
//   mem_wdata   out  32  latched write data
//   mem_ack     in   1   memory completion strobe
//   mem_rdata   in   32  memory read data, valid with mem_ack
// -----------------------------------------------------------------------------
module data_mem_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Wide enough to hold TIMEOUT_CYC itself, so the counter can never wrap.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic             mem_req_d, mem_we_d, err_d;
    logic [31:0]      mem_addr_d, mem_wdata_d, cpu_rdata_d;

    assign cnt_inc = cnt + CNT_W'(1);

    // Stall is combinational so the core freezes in the same cycle it asks.
    // It is gated by reset so a held cpu_en cannot stall the core in reset.
    assign stall = rst & (((state == IDLE) & cpu_en) | (state == BUSY));

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        cpu_rdata_d = cpu_rdata;
        err_d       = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_en) begin
                    if (cpu_addr[1:0] == 2'b00) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end else begin
                        // Misaligned: never touch memory, report and finish.
                        err_d       = 1'b1;
                        cpu_rdata_d = '0;
                        state_d     = DONE;
                    end
                end
            end

            BUSY: begin
                // Ack is tested first so an ack in the timeout cycle wins.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we) begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_inc == CNT_LIMIT) begin
                    cnt_d       = cnt_inc;
                    mem_req_d   = 1'b0;
                    err_d       = 1'b1;
                    cpu_rdata_d = TIMEOUT_DATA;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cpu_rdata <= cpu_rdata_d;
            err       <= err_d;
        end
    end

endmodule
